pipe_reg: RTL and testbench

PIPE_REG -- requirements
Module: pipe_reg

---
 rtl/pipe_reg_pkg.sv | 11 +
 rtl/pipe_reg.sv | 96 +++++++++
 tb/tb_pipe_reg.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/pipe_reg_pkg.sv
// Shared definitions for the pipe_reg two-entry skid buffer: occupancy state
// encoding, whose numeric value doubles as the held-word count.
package pipe_reg_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } pipe_state_t;

endpackage : pipe_reg_pkg

// File: rtl/pipe_reg.sv
// Two-entry pipeline register (main + skid) with valid/ready handshake on both
// sides, a fully registered in_ready, flush and synchronous reset.
module pipe_reg #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [1:0]       count
);
    import pipe_reg_pkg::*;

    pipe_state_t      state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             in_ready_q;
    logic             in_xfer_s;
    logic             out_xfer_s;

    assign in_xfer_s  = in_valid && in_ready_q;
    assign out_xfer_s = (state_q != EMPTY) && out_ready;

    // Next-state and data-register selection; flush wins over every transfer.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_xfer_s) begin
                        main_d  = in_data;
                        state_d = ONE;
                    end else begin
                        state_d = EMPTY;
                    end
                end
                ONE: begin
                    if (in_xfer_s && out_xfer_s) begin
                        main_d  = in_data;
                        state_d = ONE;
                    end else if (in_xfer_s) begin
                        skid_d  = in_data;
                        state_d = TWO;
                    end else if (out_xfer_s) begin
                        state_d = EMPTY;
                    end else begin
                        state_d = ONE;
                    end
                end
                TWO: begin
                    if (out_ready) begin
                        main_d  = skid_q;
                        state_d = ONE;
                    end else begin
                        state_d = TWO;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
    end

    // State, data and ready registers; in_ready is precomputed from state_d so
    // out_ready never reaches it combinationally.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= EMPTY;
            main_q     <= RESET_VAL;
            skid_q     <= RESET_VAL;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= (state_d != TWO);
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_q;
    assign count     = state_q;

endmodule : pipe_reg

// File: tb/tb_pipe_reg.sv
// Self-checking bench for pipe_reg: an 8-bit and a 32-bit instance driven in
// lockstep and compared every cycle against a queue-based reference model.
module tb_pipe_reg;

    localparam logic [7:0]  RV8  = 8'hA5;
    localparam logic [31:0] RV32 = 32'h0BAD_F00D;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic [31:0] din;

    logic        ir8, ov8, ir32, ov32;
    logic [1:0]  cnt8, cnt32;
    logic [7:0]  od8;
    logic [31:0] od32;

    int checks = 0;
    int errors = 0;

    // Reference model: words held, oldest first, plus the last word shown.
    logic [31:0] mq[$];
    logic [7:0]  m8;
    logic [31:0] m32;

    always #5 clk = ~clk;

    pipe_reg #(.WIDTH(8), .RESET_VAL(RV8)) dut8 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_data(din[7:0]), .in_ready(ir8),
        .out_valid(ov8), .out_data(od8), .out_ready(out_ready), .count(cnt8)
    );

    pipe_reg #(.WIDTH(32), .RESET_VAL(RV32)) dut32 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_data(din), .in_ready(ir32),
        .out_valid(ov32), .out_data(od32), .out_ready(out_ready), .count(cnt32)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        int  n;
        logic pop, push;
        n = mq.size();
        if (rst) begin
            mq.delete();
            m8  = RV8;
            m32 = RV32;
        end else if (flush) begin
            mq.delete();
        end else begin
            pop  = (n > 0) && out_ready;
            push = in_valid && (n < 2);
            if (pop)  void'(mq.pop_front());
            if (push) mq.push_back(din);
            if (mq.size() > 0) begin
                m32 = mq[0];
                m8  = m32[7:0];
            end
        end
    endtask

    task automatic compare();
        int n;
        n = mq.size();
        chk("out_valid8",  {63'd0, ov8},  {63'd0, (n > 0)});
        chk("in_ready8",   {63'd0, ir8},  {63'd0, (n < 2)});
        chk("count8",      {62'd0, cnt8}, 64'(n));
        chk("out_data8",   {56'd0, od8},  {56'd0, m8});
        chk("out_valid32", {63'd0, ov32}, {63'd0, (n > 0)});
        chk("in_ready32",  {63'd0, ir32}, {63'd0, (n < 2)});
        chk("count32",     {62'd0, cnt32}, 64'(n));
        chk("out_data32",  {32'd0, od32}, {32'd0, m32});
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare();
    endtask

    task automatic drive(input logic r, input logic f, input logic v, input logic [31:0] d, input logic o);
        rst = r; flush = f; in_valid = v; din = d; out_ready = o;
    endtask

    initial begin
        m8 = RV8;
        m32 = RV32;
        drive(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);

        // Reset
        tick();
        chk("rst_out_valid", {63'd0, ov8}, 64'd0);
        chk("rst_in_ready",  {63'd0, ir8}, 64'd1);
        chk("rst_count",     {62'd0, cnt8}, 64'd0);
        chk("rst_out_data8", {56'd0, od8}, 64'h0000_0000_0000_00A5);
        chk("rst_out_data32", {32'd0, od32}, 64'h0000_0000_0BAD_F00D);

        // Streaming 1..4 at full rate
        for (int k = 1; k <= 4; k++) begin
            drive(1'b0, 1'b0, 1'b1, 32'(k), 1'b1);
            tick();
            chk("stream_data",  {56'd0, od8}, 64'(k));
            chk("stream_count", {62'd0, cnt8}, 64'd1);
            chk("stream_ready", {63'd0, ir8}, 64'd1);
        end
        drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
        tick();
        chk("stream_drain", {62'd0, cnt8}, 64'd0);

        // Backpressure: 11, 22 fill, 33 refused while full
        drive(1'b0, 1'b0, 1'b1, 32'h11, 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b1, 32'h22, 1'b0);
        tick();
        chk("bp_count", {62'd0, cnt8}, 64'd2);
        chk("bp_ready", {63'd0, ir8}, 64'd0);
        chk("bp_data",  {56'd0, od8}, 64'h11);
        drive(1'b0, 1'b0, 1'b1, 32'h33, 1'b0);
        tick();
        chk("bp_hold_count", {62'd0, cnt8}, 64'd2);
        chk("bp_hold_data",  {56'd0, od8}, 64'h11);
        drive(1'b0, 1'b0, 1'b1, 32'h33, 1'b1);
        tick();
        chk("bp_second", {56'd0, od8}, 64'h22);
        tick();
        chk("bp_third", {56'd0, od8}, 64'h33);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        tick();
        chk("bp_empty", {63'd0, ov8}, 64'd0);

        // Flush while full with an offered word and out_ready high
        drive(1'b0, 1'b0, 1'b1, 32'h44, 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b1, 32'h55, 1'b0);
        tick();
        drive(1'b0, 1'b1, 1'b1, 32'h66, 1'b1);
        tick();
        chk("flush_count", {62'd0, cnt8}, 64'd0);
        chk("flush_valid", {63'd0, ov8}, 64'd0);
        chk("flush_ready", {63'd0, ir8}, 64'd1);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("flush_quiet", {63'd0, ov8}, 64'd0);
        end

        // Reset in ONE while in_valid is high
        drive(1'b0, 1'b0, 1'b1, 32'h12, 1'b0);
        tick();
        drive(1'b1, 1'b0, 1'b1, 32'h34, 1'b1);
        tick();
        chk("mrst_count", {62'd0, cnt8}, 64'd0);
        chk("mrst_data",  {56'd0, od8}, 64'hA5);
        drive(1'b0, 1'b0, 1'b1, 32'h7E, 1'b0);
        tick();
        chk("mrst_next_valid", {63'd0, ov8}, 64'd1);
        chk("mrst_next_data",  {56'd0, od8}, 64'h7E);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        tick();

        // Wide words
        drive(1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1);
        tick();
        chk("wide_word0", {32'd0, od32}, 64'h0000_0000_DEAD_BEEF);
        chk("wide_low0",  {56'd0, od8},  64'hEF);
        drive(1'b0, 1'b0, 1'b1, 32'h0000_0001, 1'b1);
        tick();
        chk("wide_word1", {32'd0, od32}, 64'h0000_0000_0000_0001);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        tick();

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            drive(($urandom_range(0, 199) == 0),
                  ($urandom_range(0, 49) == 0),
                  ($urandom_range(0, 3) != 0),
                  $urandom(),
                  ($urandom_range(0, 2) != 0));
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_pipe_reg
